// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM encodings, NOP word and
// the IF/ID payload struct.
package fetch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pcp4;
        logic [31:0] instr;
    } ifid_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load takes priority over clear; clear leaves a NOP bubble.
module ifid_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  ifid_t       din,
    output logic [31:0] pcp4,
    output logic [31:0] instr,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcp4  <= 32'h0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            pcp4  <= din.pcp4;
            instr <= din.instr;
            valid <= 1'b1;
        end else if (clear) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// PC register, single-outstanding instruction fetch FSM and IF/ID register.
// Define BRANCH_DELAY_SLOT_EN to deliver the delay-slot instruction instead of squashing it.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic [31:0] NPC_i,
    input  logic        isRedirect,
    input  logic        ID_Stall,
    output logic [31:0] IF_ID_PCPlusBy4,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid,
    output state_t      fsm_state
);

    // Handshake: imem_req high means one request is outstanding at imem_addr;
    // it completes in the cycle imem_valid is high, and imem_addr never changes
    // while the request waits. imem_valid with imem_req low is ignored.

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    ifid_t       hold, hold_n;
    ifid_t       ifid_din;
    logic        ifid_load, ifid_clear;
    logic        resp, fetch_done, redir;
    logic [31:0] npc, pc_inc;

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pend_valid, pend_valid_n;
    logic [31:0] pend_target, pend_target_n;
`else
    logic        discard, discard_n;
    logic [31:0] req_addr, req_addr_n;
`endif

    assign resp   = (state == ST_FETCH) && imem_valid;
    assign redir  = isRedirect && !ID_Stall;
    assign npc    = word_align(NPC_i);
    assign pc_inc = pc + 32'd4;

`ifdef BRANCH_DELAY_SLOT_EN
    assign fetch_done = resp;
    assign imem_addr  = pc;
`else
    // A wrong-path request keeps its address on the bus while pc already holds the target.
    assign fetch_done = resp && !discard;
    assign imem_addr  = discard ? req_addr : pc;
`endif

    assign imem_req  = (state == ST_FETCH);
    assign fsm_state = state;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        hold_n     = hold;
        ifid_load  = 1'b0;
        ifid_clear = !ID_Stall;
        ifid_din   = '{pcp4: pc_inc, instr: imem_rdata};
`ifdef BRANCH_DELAY_SLOT_EN
        pend_valid_n  = pend_valid;
        pend_target_n = pend_target;
`else
        discard_n  = discard;
        req_addr_n = req_addr;
        if (resp && discard) begin
            discard_n = 1'b0;
        end
`endif

        case (state)
            ST_IDLE: begin
                state_n = ST_FETCH;
            end
            ST_FETCH: begin
                if (fetch_done) begin
                    pc_n = pc_inc;
                    if (ID_Stall) begin
                        hold_n  = '{pcp4: pc_inc, instr: imem_rdata};
                        state_n = ST_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!ID_Stall) begin
                    ifid_load = 1'b1;
                    ifid_din  = hold;
                    state_n   = ST_FETCH;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

`ifdef BRANCH_DELAY_SLOT_EN
        // The first instruction completing at or after the branch is its delay slot.
        if (redir) begin
            if (fetch_done || (state == ST_HOLD)) begin
                pc_n         = npc;
                pend_valid_n = 1'b0;
            end else begin
                pend_valid_n  = 1'b1;
                pend_target_n = npc;
            end
        end else if (pend_valid && fetch_done) begin
            pc_n         = pend_target;
            pend_valid_n = 1'b0;
        end
`else
        if (redir) begin
            ifid_load = 1'b0;
            pc_n      = npc;
            state_n   = ST_FETCH;
            if ((state == ST_FETCH) && !resp && !discard) begin
                discard_n  = 1'b1;
                req_addr_n = pc;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= RESET_VECTOR;
            hold  <= '0;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
`else
            discard  <= 1'b0;
            req_addr <= 32'h0;
`endif
        end else begin
            state <= state_n;
            pc    <= pc_n;
            hold  <= hold_n;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_valid  <= pend_valid_n;
            pend_target <= pend_target_n;
`else
            discard  <= discard_n;
            req_addr <= req_addr_n;
`endif
        end
    end

    ifid_reg u_ifid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ifid_load),
        .clear (ifid_clear),
        .din   (ifid_din),
        .pcp4  (IF_ID_PCPlusBy4),
        .instr (IF_ID_Instr),
        .valid (IF_ID_Valid)
    );

endmodule
